// File: rtl/os_sys_array_tile.sv
// -----------------------------------------------------------------------------
// os_sys_array_tile
//
// Output-stationary integer systolic array of M x K processing elements.
// Each accepted input beat carries one column of A (M operands) and one row
// of B (K operands). The block computes C = A(MxN) * B(NxK) and either starts
// from zero or accumulates onto the C left over from the previous tile. The
// finished C is drained one row per output handshake.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   tile_start    start pulse, only looked at while idle
//   acc_keep      sampled with tile_start: 1 keeps accumulators and ovf
//   in_valid      input beat valid
//   in_ready      high while the array is accepting beats
//   in_stream     A[i][k] at [i*DATA_W +: DATA_W], B[k][j] at [(M+j)*DATA_W +: DATA_W]
//   out_valid     result row valid
//   out_ready     downstream ready
//   out_stream    C[r][j] at [j*ACC_W +: ACC_W], zero when out_valid is low
//   out_last      marks row M-1
//   busy          any state other than idle
//   done          one-cycle pulse after the final drain handshake
//   ovf           sticky: some accumulator overflowed during this tile
// -----------------------------------------------------------------------------
module os_sys_array_tile #(
    parameter int M        = 4,
    parameter int K        = 4,
    parameter int N        = 8,
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 40,
    parameter int SATURATE = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tile_start,
    input  logic                      acc_keep,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [(M+K)*DATA_W-1:0]   in_stream,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [K*ACC_W-1:0]        out_stream,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done,
    output logic                      ovf
);

    localparam int BEAT_W  = (N > 1) ? $clog2(N) : 1;
    localparam int FLUSH_W = (M + K - 1 > 1) ? $clog2(M + K - 1) : 1;
    localparam int ROW_W   = (M > 1) ? $clog2(M) : 1;

    localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(N - 1);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(M + K - 2);
    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(M - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_FLUSH   = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [FLUSH_W-1:0]   flush_q, flush_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ovf_q, ovf_d;

    // start: accepted tile_start; adv: whole array takes one step this cycle
    logic                 start;
    logic                 adv;
    logic [M*K-1:0]       pe_ovf;

    logic signed [DATA_W-1:0] a_edge [M];
    logic signed [DATA_W-1:0] b_edge [K];
    logic signed [DATA_W-1:0] a_pipe [M][K];
    logic signed [DATA_W-1:0] b_pipe [M][K];
    logic signed [ACC_W-1:0]  acc_all [M][K];

    assign start = (state_q == S_IDLE) && tile_start;
    // In FLUSH the array steps every cycle; in COMPUTE only on a handshake
    // (in_ready is high throughout COMPUTE, so in_valid alone is the handshake).
    assign adv   = ((state_q == S_COMPUTE) && in_valid) || (state_q == S_FLUSH);

    // -------------------------------------------------------------------------
    // Control
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        flush_d = flush_q;
        row_d   = row_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (tile_start) begin
                    state_d = S_COMPUTE;
                    beat_d  = '0;
                    if (!acc_keep) begin
                        ovf_d = 1'b0;
                    end
                end
            end
            S_COMPUTE: begin
                if (in_valid) begin
                    if (beat_q == BEAT_LAST) begin
                        state_d = S_FLUSH;
                        flush_d = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                if (flush_q == FLUSH_LAST) begin
                    state_d = S_DRAIN;
                    row_d   = '0;
                end else begin
                    flush_d = flush_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (row_q == ROW_LAST) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (adv && (|pe_ovf)) begin
            ovf_d = 1'b1;
        end
        // Handshake flags are decoded from the next state so they are flops.
        in_ready_d  = (state_d == S_COMPUTE);
        out_valid_d = (state_d == S_DRAIN);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            flush_q     <= '0;
            row_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            flush_q     <= flush_d;
            row_q       <= row_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ovf       = ovf_q;
    assign out_last  = out_valid_q && (row_q == ROW_LAST);

    always_comb begin
        out_stream = '0;
        if (out_valid_q) begin
            for (int r = 0; r < M; r++) begin
                if (row_q == ROW_W'(r)) begin
                    for (int j = 0; j < K; j++) begin
                        out_stream[j*ACC_W +: ACC_W] = acc_all[r][j];
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Input skew: row i of A is delayed by i steps, column j of B by j steps,
    // so that A[i][k] and B[k][j] meet in PE(i,j) on step k+i+j.
    // Zeros are injected whenever the block is not in COMPUTE.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < M; gi++) begin : g_skew_a
        logic signed [DATA_W-1:0] inj;
        assign inj = (state_q == S_COMPUTE) ? in_stream[gi*DATA_W +: DATA_W] : '0;
        if (gi == 0) begin : g_direct
            assign a_edge[gi] = inj;
        end else begin : g_chain
            logic signed [DATA_W-1:0] chain_q [gi];
            logic signed [DATA_W-1:0] chain_d [gi];
            always_comb begin
                for (int s = 0; s < gi; s++) begin
                    chain_d[s] = chain_q[s];
                end
                if (start) begin
                    for (int s = 0; s < gi; s++) begin
                        chain_d[s] = '0;
                    end
                end else if (adv) begin
                    chain_d[0] = inj;
                    for (int s = 1; s < gi; s++) begin
                        chain_d[s] = chain_q[s-1];
                    end
                end
            end
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s < gi; s++) begin
                        chain_q[s] <= '0;
                    end
                end else begin
                    for (int s = 0; s < gi; s++) begin
                        chain_q[s] <= chain_d[s];
                    end
                end
            end
            assign a_edge[gi] = chain_q[gi-1];
        end
    end

    for (genvar gj = 0; gj < K; gj++) begin : g_skew_b
        logic signed [DATA_W-1:0] inj;
        assign inj = (state_q == S_COMPUTE) ? in_stream[(M+gj)*DATA_W +: DATA_W] : '0;
        if (gj == 0) begin : g_direct
            assign b_edge[gj] = inj;
        end else begin : g_chain
            logic signed [DATA_W-1:0] chain_q [gj];
            logic signed [DATA_W-1:0] chain_d [gj];
            always_comb begin
                for (int s = 0; s < gj; s++) begin
                    chain_d[s] = chain_q[s];
                end
                if (start) begin
                    for (int s = 0; s < gj; s++) begin
                        chain_d[s] = '0;
                    end
                end else if (adv) begin
                    chain_d[0] = inj;
                    for (int s = 1; s < gj; s++) begin
                        chain_d[s] = chain_q[s-1];
                    end
                end
            end
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s < gj; s++) begin
                        chain_q[s] <= '0;
                    end
                end else begin
                    for (int s = 0; s < gj; s++) begin
                        chain_q[s] <= chain_d[s];
                    end
                end
            end
            assign b_edge[gj] = chain_q[gj-1];
        end
    end

    // -------------------------------------------------------------------------
    // Processing elements
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < M; gi++) begin : g_row
        for (genvar gj = 0; gj < K; gj++) begin : g_col
            logic signed [DATA_W-1:0]   a_in, b_in;
            logic signed [DATA_W-1:0]   a_q, a_d, b_q, b_d;
            logic signed [ACC_W-1:0]    acc_q, acc_d;
            logic signed [2*DATA_W-1:0] prod;
            logic        [ACC_W:0]      sum_ext;
            logic                       hit;

            if (gj == 0) begin : g_a_west
                assign a_in = a_edge[gi];
            end else begin : g_a_inner
                assign a_in = a_pipe[gi][gj-1];
            end
            if (gi == 0) begin : g_b_north
                assign b_in = b_edge[gj];
            end else begin : g_b_inner
                assign b_in = b_pipe[gi-1][gj];
            end

            assign prod = a_in * b_in;
            // One extra bit holds the true sign of the sum; it disagrees with
            // the ACC_W result sign exactly when the addition overflowed.
            assign sum_ext = {acc_q[ACC_W-1], acc_q}
                           + {{(ACC_W + 1 - 2*DATA_W){prod[2*DATA_W-1]}}, prod};
            assign hit = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];

            always_comb begin
                a_d   = a_q;
                b_d   = b_q;
                acc_d = acc_q;
                if (start) begin
                    a_d = '0;
                    b_d = '0;
                    if (!acc_keep) begin
                        acc_d = '0;
                    end
                end else if (adv) begin
                    a_d = a_in;
                    b_d = b_in;
                    if (hit && (SATURATE != 0)) begin
                        acc_d = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                               : {1'b0, {(ACC_W-1){1'b1}}};
                    end else begin
                        acc_d = sum_ext[ACC_W-1:0];
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    acc_q <= '0;
                end else begin
                    a_q   <= a_d;
                    b_q   <= b_d;
                    acc_q <= acc_d;
                end
            end

            assign a_pipe[gi][gj]  = a_q;
            assign b_pipe[gi][gj]  = b_q;
            assign acc_all[gi][gj] = acc_q;
            assign pe_ovf[gi*K+gj] = hit;
        end
    end

endmodule

// File: doc/os_sys_array_tile.md
Name: os_sys_array_tile

Overview:
- Parametrised output-stationary integer systolic array, M x K PEs, fed by one AXI-stream-style input carrying an A column and a B row per beat.
- Computes C = A(MxN) * B(NxK), optionally accumulating onto the previous tile.
- Drains C row-by-row through a stream output with last.
- Replaces the float/DSP array top for integer workloads; adds built-in skew registers, tile accumulation, saturation and overflow reporting.

Parameters:
- M, 4, PE rows (rows of A / C)
- K, 4, PE columns (columns of B / C)
- N, 8, inner dimension = input beats per tile
- DATA_W, 16, signed operand width
- ACC_W, 40, signed accumulator width (>= 2*DATA_W)
- SATURATE, 0, 0 = wrap modulo 2^ACC_W, 1 = clamp to signed ACC_W range

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- tile_start  in  1  start pulse, sampled only in IDLE
- acc_keep  in  1  sampled with tile_start; 1 = keep accumulators, 0 = clear
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_stream  in  (M+K)*DATA_W  A[i][k] at [i*DATA_W +: DATA_W]; B[k][j] at [(M+j)*DATA_W +: DATA_W]
- out_valid  out  1  result row valid
- out_ready  in  1  downstream ready
- out_stream  out  K*ACC_W  C[r][j] at [j*ACC_W +: ACC_W]
- out_last  out  1  high with row M-1
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after final drain handshake
- ovf  out  1  sticky per tile: any accumulator overflowed

Behaviour:
- Reset: all outputs 0, state IDLE, accumulators, skew and pipeline registers 0.
- Reset mid-operation aborts the tile immediately; no partial output.

States:
- IDLE: in_ready=0, out_valid=0.
  - On tile_start go to COMPUTE.
  - If acc_keep=0: clear accumulators and ovf.
  - If acc_keep=1: hold both.
- COMPUTE: in_ready=1.
  - Each handshake advances the array one step and increments the beat counter.
  - No handshake: the whole array stalls; data, accumulators and skew are held.
  - After beat N-1 go to FLUSH.
- FLUSH:
  - Array advances every cycle with zero operands injected.
  - Lasts exactly M+K-1 cycles, then DRAIN.
- DRAIN: out_valid=1, out_stream = row r (r counter from 0).
  - Output holds stable while out_valid & ~out_ready.
  - Each handshake increments r.
  - Handshake at r=M-1 (out_last=1) -> IDLE; done=1 on the following cycle.

Array:
- Row i input passes through i skew registers; column j input through j.
- Operands move right (A) and down (B) one PE per advance.
- PE(i,j): acc += a*b, full signed 2*DATA_W product sign-extended to ACC_W.

Overflow:
- Detected when the sign of the true sum differs from the ACC_W result.
- Sets ovf in both modes.
- SATURATE=1 clamps to +(2^(ACC_W-1)-1) or -2^(ACC_W-1); SATURATE=0 wraps.

Boundaries:
- tile_start outside IDLE: ignored.
- in_valid outside COMPUTE: ignored; no data consumed.
- Minimum tile latency, no stalls: 1 + N + (M+K-1) cycles from tile_start to first out_valid.

Test Plan:
- Basic product, M=K=N=2, DATA_W=8, ACC_W=20.
  - Stimulus: acc_keep=0, beats {A0=1,A1=3,B0=5,B1=6}, {2,4,7,8}.
  - Required: rows [19,22], [43,50]; out_last on row 1; done pulse; ovf=0.
- Accumulate: same tile again with acc_keep=1 -> rows [38,44], [86,100].
- Input bubbles: 3-cycle in_valid gaps between beats, out_ready toggling 1/0 -> identical results; out_stream stable during stalls; in_ready low outside COMPUTE.
- Saturation: DATA_W=8, ACC_W=16, N=2, all operands -128.
  - SATURATE=1: every C = 32767, ovf=1.
  - SATURATE=0: every C = -32768, ovf=1.
- Reset mid-tile: assert rst after first beat -> all outputs 0 at once; a new tile from the basic-product test then yields [19,22], [43,50].
- Protocol: tile_start pulsed during COMPUTE and DRAIN -> ignored, results unchanged; extra in_valid in IDLE/DRAIN -> not consumed.
